sync_fifo_bypass: RTL and testbench

SYNC_FIFO_BYPASS -- requirements
Module: sync_fifo_bypass

---
 rtl/sync_fifo_bypass_pkg.sv | 13 +
 rtl/sync_fifo_core.sv | 56 +++++
 rtl/sync_fifo_bypass.sv | 64 ++++++
 tb/tb_sync_fifo_bypass.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_bypass_pkg.sv
// Shared constants and sizing helpers for the bypass FIFO.
// Used by sync_fifo_bypass (SYNC_FIFO_BYPASS_EN selects the bypass path) and sync_fifo_core.
package sync_fifo_bypass_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 8;

  // One extra bit so the counter can hold DEPTH itself.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Storage, pointers and occupancy for the bypass FIFO; dout is the current head entry.
module sync_fifo_core
  import sync_fifo_bypass_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo_bypass.sv
// FIFO with arbiter handshake and registered output; SYNC_FIFO_BYPASS_EN adds the
// empty-FIFO bypass so a granted write appears one cycle later without being stored.
module sync_fifo_bypass
  import sync_fifo_bypass_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             i_WrEn,
  input  logic [WIDTH-1:0] i_WrData,
  input  logic             i_Grant,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Grant
);

  logic             fifo_empty;
  logic             fifo_full;
  logic [WIDTH-1:0] head;
  logic             granted;
  logic             bypass;
  logic             pop;
  logic             push;

`ifdef SYNC_FIFO_BYPASS_EN
  assign o_Grant = i_WrEn | ~fifo_empty;
  // Granted while empty can only come from i_WrEn, so the write goes straight out.
  assign bypass  = granted & fifo_empty;
`else
  assign o_Grant = ~fifo_empty;
  assign bypass  = 1'b0;
`endif

  assign granted = i_Grant & o_Grant;
  assign pop     = granted & ~fifo_empty;
  assign push    = i_WrEn & ~bypass & (~fifo_full | pop);

  sync_fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (CLK),
    .reset (Reset),
    .push  (push),
    .pop   (pop),
    .din   (i_WrData),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      o_Valid <= 1'b0;
      o_Data  <= '0;
    end else begin
      o_Valid <= granted;
      if (granted) o_Data <= bypass ? i_WrData : head;
    end
  end

endmodule

// File: tb/tb_sync_fifo_bypass.sv
// Self-checking bench for sync_fifo_bypass: hand vectors, directed sequences and random
// traffic against a queue model; follows SYNC_FIFO_BYPASS_EN to pick the expected mode.
module tb_sync_fifo_bypass;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
`ifdef SYNC_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             Reset;
  logic             i_WrEn;
  logic [WIDTH-1:0] i_WrData;
  logic             i_Grant;
  logic             o_Valid;
  logic [WIDTH-1:0] o_Data;
  logic             o_Grant;
  logic             sel;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [WIDTH-1:0] mq[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_data;

  assign i_Grant = sel & o_Grant;
  always #5 CLK = ~CLK;

  sync_fifo_bypass #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .i_WrEn   (i_WrEn),
    .i_WrData (i_WrData),
    .i_Grant  (i_Grant),
    .o_Valid  (o_Valid),
    .o_Data   (o_Data),
    .o_Grant  (o_Grant)
  );

  typedef struct {
    logic             rst;
    logic             we;
    logic [WIDTH-1:0] d;
    logic             s;
    logic             g_b;
    logic             g_n;
    logic             v;
    logic [WIDTH-1:0] q;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic we, input logic [WIDTH-1:0] d,
                       input logic s, output logic g_o, output logic v_o,
                       output logic [WIDTH-1:0] d_o);
    logic exp_g;
    logic granted;
    Reset = rst; i_WrEn = we; i_WrData = d; sel = s;
    #1;
    exp_g = BYP ? (we || mq.size() != 0) : (mq.size() != 0);
    g_o = o_Grant;
    check("model_grant", g_o, exp_g);
    granted = s && exp_g;
    if (rst) begin
      mq.delete();
      m_valid = 1'b0;
      m_data  = '0;
    end else if (granted) begin
      m_valid = 1'b1;
      if (mq.size() != 0) begin
        m_data = mq.pop_front();
        if (we) mq.push_back(d);
      end else begin
        m_data = d;
      end
    end else begin
      m_valid = 1'b0;
      if (we && mq.size() < DEPTH) mq.push_back(d);
    end
    @(posedge CLK); #1;
    v_o = o_Valid;
    d_o = o_Data;
    check("model_valid", v_o, m_valid);
    check("model_data", d_o, m_data);
    @(negedge CLK);
  endtask

  task automatic step(input logic rst, input logic we, input logic [WIDTH-1:0] d, input logic s);
    logic g, v;
    logic [WIDTH-1:0] q;
    cycle(rst, we, d, s, g, v, q);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic g, v;
    logic [WIDTH-1:0] q;

    //            rst   we    d      s     g_b   g_n   v     q
    vecs[0]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 8'd5,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 8'd6,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 8'd7,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 8'd8,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 1'b1, 8'd5};
    vecs[7]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 1'b1, 8'd6};
    vecs[8]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 1'b1, 8'd7};
    vecs[9]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 1'b1, 8'd8};
    vecs[10] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd8};
    vecs[11] = '{1'b0, 1'b1, 8'd9,  1'b0, 1'b1, 1'b0, 1'b0, 8'd8};
    vecs[12] = '{1'b0, 1'b1, 8'd10, 1'b0, 1'b1, 1'b1, 1'b0, 8'd8};
    vecs[13] = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[14] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    Reset = 1'b1; i_WrEn = 1'b0; i_WrData = '0; sel = 1'b0;
    m_valid = 1'b0; m_data = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].rst, vecs[i].we, vecs[i].d, vecs[i].s, g, v, q);
      check($sformatf("vec%0d_grant", i), g, BYP ? vecs[i].g_b : vecs[i].g_n);
      check($sformatf("vec%0d_valid", i), v, vecs[i].v);
      check($sformatf("vec%0d_data", i), q, vecs[i].q);
    end

    // write-through with grant held
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b1);
    drain(5);

    // stored data drains ahead of new writes
    for (int i = 5; i <= 8; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b0);
    for (int i = 9; i <= 12; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b1);
    drain(6);

    // FIFO empties just as fresh writes arrive
    for (int i = 13; i <= 16; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b0);
    drain(4);
    for (int i = 17; i <= 20; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b1);
    drain(6);

    // overflow drops the excess writes
    for (int i = 21; i <= 30; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b0);
    drain(10);

    // full FIFO accepts a push alongside a pop
    for (int i = 31; i <= 38; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b0);
    for (int i = 39; i <= 42; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b1);
    drain(13);

    // reset discards stored entries
    for (int i = 43; i <= 45; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), WIDTH'($urandom),
           $urandom_range(0, 2) != 0);
    end
    drain(DEPTH + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
